instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory interface. Owns the program counter and drives the word-aligned byte address into instruction memory. Captures the returned 32-bit instruction word into an instruction register for decode, and resolves J-type jumps and the Stop bit locally. Accepts stalls and redirects from later pipeline stages.

---
 rtl/instruction_fetch_unit.sv | 70 +++++++
 tb/tb_instruction_fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches words, resolves J-type jumps and Stop locally
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] AddressBus,
  input  logic [31:0] InstructionWord,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] IR,
  output logic [31:0] IR_pc,
  output logic        ir_valid,
  output logic        halted
);
  localparam logic [1:0] TYPE_J = 2'b10;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ir_pc_q, ir_pc_d, j_off;
  logic        valid_q, valid_d, halt_q, halt_d, is_j, is_stop, unused_rt;
  assign is_j      = InstructionWord[2:1] == TYPE_J;
  assign is_stop   = InstructionWord[0];
  assign j_off     = {{6{InstructionWord[26]}}, InstructionWord[26:3], 2'b00};
  assign unused_rt = ^redirect_target[1:0];
  // next state: redirect beats stall beats halt; jumps are consumed here and never reach IR
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      valid_d = 1'b0;
      halt_d  = 1'b0;
    end else if (!stall) begin
      valid_d = !halt_q && !is_j;
      if (!halt_q) begin
        halt_d = is_stop;
        if (is_j) begin
          pc_d = pc_q + j_off;
        end else begin
          ir_d    = InstructionWord;
          ir_pc_d = pc_q;
          pc_d    = is_stop ? pc_q : pc_q + 32'd4;
        end
      end
    end
  end
  // fetch state registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end
  assign AddressBus = pc_q;
  assign IR         = ir_q;
  assign IR_pc      = ir_pc_q;
  assign ir_valid   = valid_q;
  assign halted     = halt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed cycle tables against a small instruction memory
module tb_instruction_fetch_unit;
  logic        clock = 1'b0, reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] AddressBus, InstructionWord, IR, IR_pc;
  logic        ir_valid, halted;
  logic [31:0] mem [0:63];
  int total = 0, bad = 0;

  localparam logic [31:0] A1 = 32'h1000_0010, A2 = 32'h2000_0022, A3 = 32'h3000_0030,
                          A4 = 32'h4000_0046, JM2 = 32'h07FF_FFF4, S = 32'h5000_0003,
                          B0 = 32'h6000_0060, B1 = 32'h7000_0070, Z = 32'h8000_0080;

  typedef struct {
    logic        st, rv;
    logic [31:0] rt, addr, irpc, ir;
    logic        v, h;
  } vec_t;

  vec_t va [9];
  vec_t vb [16];

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .AddressBus(AddressBus), .InstructionWord(InstructionWord),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .IR(IR), .IR_pc(IR_pc), .ir_valid(ir_valid), .halted(halted)
  );

  assign InstructionWord = mem[AddressBus[7:2]];

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " AddressBus"}, AddressBus, v.addr);
    chk({tag, " IR_pc"}, IR_pc, v.irpc);
    chk({tag, " IR"}, IR, v.ir);
    chk({tag, " ir_valid"}, {31'd0, ir_valid}, {31'd0, v.v});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.h});
  endtask

  task automatic run_row(input string tag, input vec_t v);
    stall = v.st;
    redirect_valid = v.rv;
    redirect_target = v.rt;
    @(posedge clock);
    @(negedge clock);
    check_all(tag, v);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[1] = A1; mem[2] = A2; mem[3] = A3; mem[4] = A4; mem[5] = JM2;
    va[0] = '{0, 0, 0, 32'd8,  32'd4,  A1, 1, 0};
    va[1] = '{0, 0, 0, 32'd12, 32'd8,  A2, 1, 0};
    va[2] = '{1, 0, 0, 32'd12, 32'd8,  A2, 1, 0};
    va[3] = '{1, 0, 0, 32'd12, 32'd8,  A2, 1, 0};
    va[4] = '{1, 0, 0, 32'd12, 32'd8,  A2, 1, 0};
    va[5] = '{0, 0, 0, 32'd16, 32'd12, A3, 1, 0};
    va[6] = '{0, 0, 0, 32'd20, 32'd16, A4, 1, 0};
    va[7] = '{0, 0, 0, 32'd12, 32'd16, A4, 0, 0};
    va[8] = '{0, 0, 0, 32'd16, 32'd12, A3, 1, 0};
    vb[0] = '{0, 0, 0, 32'd8, 32'd4, A1, 1, 0};
    vb[1] = '{0, 0, 0, 32'd8, 32'd8, S,  1, 1};
    for (int i = 2; i < 12; i++) vb[i] = '{0, 0, 0, 32'd8, 32'd8, S, 0, 1};
    vb[12] = '{1, 1, 32'h0000_0043, 32'h40, 32'd8,  S,  0, 0};
    vb[13] = '{0, 0, 0,             32'h44, 32'h40, B0, 1, 0};
    vb[14] = '{0, 0, 0,             32'h48, 32'h44, B1, 1, 0};
    vb[15] = '{0, 1, 32'h0000_0040, 32'h40, 32'h44, B1, 0, 0};

    @(negedge clock);
    @(negedge clock);
    check_all("reset", '{0, 0, 0, 32'd4, 32'd0, 32'd0, 0, 0});
    reset = 1'b1;
    chk("addr before first edge", AddressBus, 32'd4);
    for (int i = 0; i < 9; i++) run_row($sformatf("seqA%0d", i), va[i]);

    reset = 1'b0;
    @(negedge clock);
    mem[2] = S; mem[16] = B0; mem[17] = B1; mem[63] = Z; mem[5] = '0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) run_row($sformatf("seqB%0d", i), vb[i]);

    stall = 1'b1;
    #2 reset = 1'b0;
    #1 check_all("async reset", '{0, 0, 0, 32'd4, 32'd0, 32'd0, 0, 0});
    @(negedge clock);
    stall = 1'b0;
    reset = 1'b1;
    run_row("restart", '{0, 0, 0, 32'd8, 32'd4, A1, 1, 0});

    run_row("wrap redirect", '{0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd4, A1, 0, 0});
    run_row("wrap fetch",    '{0, 0, 0, 32'd0, 32'hFFFF_FFFC, Z, 1, 0});
    run_row("word zero",     '{0, 0, 0, 32'd4, 32'd0, 32'd0, 1, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
